// File: rtl/image_tx_streamer_pkg.sv
// Shared types for the image transmit path: pixel layout, transmit geometry,
// channel ids and the streamer FSM states.
package image_tx_streamer_pkg;

    typedef logic [7:0] colorChannel_t;

    typedef struct packed {
        colorChannel_t red;
        colorChannel_t green;
        colorChannel_t blue;
    } pixel_t;

    // Output frame is the input image minus the border consumed by the cell window.
    localparam int txImageWidth  = 638;
    localparam int txImageHeight = 478;

    typedef enum logic [1:0] {
        RED   = 2'd0,
        GREEN = 2'd1,
        BLUE  = 2'd2
    } txChannel_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEND_R = 2'd1,
        SEND_G = 2'd2,
        SEND_B = 2'd3
    } tx_state_t;

endpackage

// File: rtl/pixel_fifo.sv
// Small power-of-two pixel buffer; exposes the head and the entry behind it so
// the streamer can load the next pixel in the same cycle it pops the current one.
module pixel_fifo
    import image_tx_streamer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        push,
    input  logic [23:0] wr_data,
    input  logic        pop,
    output logic [23:0] head,
    output logic [23:0] head_next,
    output logic        full,
    output logic        empty,
    output logic        more_than_one
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    pixel_t         mem_q [DEPTH];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]  rd_ptr_next;
    logic [CW-1:0]  count_q, count_d;
    logic           push_ok;
    logic           pop_ok;

    assign push_ok       = push && !full;
    assign pop_ok        = pop && !empty;
    assign rd_ptr_next   = rd_ptr_q + AW'(1);
    assign head          = mem_q[rd_ptr_q];
    assign head_next     = mem_q[rd_ptr_next];
    assign full          = (count_q == CW'(DEPTH));
    assign empty         = (count_q == '0);
    assign more_than_one = (count_q > CW'(1));

    // Flush wins over any push or pop arriving in the same cycle.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop_ok)  rd_ptr_d = rd_ptr_next;
            case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok && !flush) mem_q[wr_ptr_q] <= pixel_t'(wr_data);
    end

endmodule

// File: rtl/image_tx_streamer.sv
// Serialises buffered pixels into red/green/blue byte beats with frame
// position markers for the transmit link.
module image_tx_streamer
    import image_tx_streamer_pkg::*;
#(
    parameter int TX_W       = txImageWidth,
    parameter int TX_H       = txImageHeight,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        in_valid,
    input  logic [23:0] in_pixel,
    output logic        in_ready,
    output logic        out_valid,
    output logic [7:0]  out_data,
    output logic [1:0]  out_chan,
    output logic        out_sof,
    output logic        out_eol,
    output logic        out_eof,
    input  logic        out_ready,
    output logic        frame_done
);

    localparam int COL_W = (TX_W > 1) ? $clog2(TX_W) : 1;
    localparam int ROW_W = (TX_H > 1) ? $clog2(TX_H) : 1;
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(TX_W - 1);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(TX_H - 1);

    tx_state_t        state_q, state_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic             alive_q;
    logic             out_valid_q, out_valid_d;
    colorChannel_t    out_data_q, out_data_d;
    txChannel_t       out_chan_q, out_chan_d;
    logic             out_sof_q, out_sof_d;
    logic             out_eol_q, out_eol_d;
    logic             out_eof_q, out_eof_d;
    logic             frame_done_q, frame_done_d;

    logic [23:0]      fifo_head;
    logic [23:0]      fifo_head_next;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_multi;
    logic             push;
    logic             pop;
    logic             out_xfer;
    pixel_t           head_px;

    assign in_ready   = alive_q && !fifo_full;
    assign push       = in_valid && in_ready;
    assign out_xfer   = out_valid_q && out_ready;
    assign pop        = out_xfer && (state_q == SEND_B) && !flush;

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_chan   = out_chan_q;
    assign out_sof    = out_sof_q;
    assign out_eol    = out_eol_q;
    assign out_eof    = out_eof_q;
    assign frame_done = frame_done_q;

    pixel_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .push         (push),
        .wr_data      (in_pixel),
        .pop          (pop),
        .head         (fifo_head),
        .head_next    (fifo_head_next),
        .full         (fifo_full),
        .empty        (fifo_empty),
        .more_than_one(fifo_multi)
    );

    // Outputs are recomputed from the next state, so a stalled beat reproduces
    // itself exactly and a blue pop loads the following pixel without a bubble.
    always_comb begin
        state_d      = state_q;
        col_d        = col_q;
        row_d        = row_q;
        frame_done_d = 1'b0;
        head_px      = pixel_t'(fifo_head);
        if (flush) begin
            state_d = IDLE;
            col_d   = '0;
            row_d   = '0;
        end else begin
            case (state_q)
                IDLE:    if (!fifo_empty) state_d = SEND_R;
                SEND_R:  if (out_xfer) state_d = SEND_G;
                SEND_G:  if (out_xfer) state_d = SEND_B;
                SEND_B: begin
                    if (out_xfer) begin
                        state_d      = fifo_multi ? SEND_R : IDLE;
                        head_px      = pixel_t'(fifo_head_next);
                        frame_done_d = out_eof_q;
                        if (col_q == LAST_COL) begin
                            col_d = '0;
                            row_d = (row_q == LAST_ROW) ? '0 : row_q + ROW_W'(1);
                        end else begin
                            col_d = col_q + COL_W'(1);
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        out_valid_d = 1'b0;
        out_data_d  = '0;
        out_chan_d  = RED;
        out_sof_d   = 1'b0;
        out_eol_d   = 1'b0;
        out_eof_d   = 1'b0;
        case (state_d)
            SEND_R: begin
                out_valid_d = 1'b1;
                out_data_d  = head_px.red;
                out_chan_d  = RED;
                out_sof_d   = (col_d == '0) && (row_d == '0);
            end
            SEND_G: begin
                out_valid_d = 1'b1;
                out_data_d  = head_px.green;
                out_chan_d  = GREEN;
            end
            SEND_B: begin
                out_valid_d = 1'b1;
                out_data_d  = head_px.blue;
                out_chan_d  = BLUE;
                out_eol_d   = (col_d == LAST_COL);
                out_eof_d   = (col_d == LAST_COL) && (row_d == LAST_ROW);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            col_q        <= '0;
            row_q        <= '0;
            alive_q      <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_chan_q   <= RED;
            out_sof_q    <= 1'b0;
            out_eol_q    <= 1'b0;
            out_eof_q    <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            alive_q      <= 1'b1;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_chan_q   <= out_chan_d;
            out_sof_q    <= out_sof_d;
            out_eol_q    <= out_eol_d;
            out_eof_q    <= out_eof_d;
            frame_done_q <= frame_done_d;
        end
    end

endmodule

// File: tb/tb_image_tx_streamer.sv
// Directed bench for image_tx_streamer on a 4x2 frame with a 4-entry buffer;
// a reference queue of expected beats is built from every accepted pixel.
module tb_image_tx_streamer;

    localparam int TX_W = 4;
    localparam int TX_H = 2;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic [23:0] in_pixel;
    logic        in_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic [1:0]  out_chan;
    logic        out_sof;
    logic        out_eol;
    logic        out_eof;
    logic        out_ready;
    logic        frame_done;

    int          n_compared;
    int          n_mismatched;
    int          beat_cnt;
    int          pos_col;
    int          pos_row;
    logic        push_en;
    logic        check_b24;
    logic [23:0] src_q[$];
    logic [12:0] exp_q[$];

    image_tx_streamer #(
        .TX_W      (TX_W),
        .TX_H      (TX_H),
        .FIFO_DEPTH(4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_pixel  (in_pixel),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_chan  (out_chan),
        .out_sof   (out_sof),
        .out_eol   (out_eol),
        .out_eof   (out_eof),
        .out_ready (out_ready),
        .frame_done(frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_compared++;
        if (observed !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Expected beats for one accepted pixel at the model's current frame position.
    task automatic modelPush(input logic [23:0] px);
        logic last_col;
        logic first;
        logic last_row;
        first    = (pos_col == 0) && (pos_row == 0);
        last_col = (pos_col == TX_W - 1);
        last_row = (pos_row == TX_H - 1);
        exp_q.push_back({px[23:16], 2'd0, first, 1'b0, 1'b0});
        exp_q.push_back({px[15:8],  2'd1, 1'b0, 1'b0, 1'b0});
        exp_q.push_back({px[7:0],   2'd2, 1'b0, last_col, last_col && last_row});
        if (last_col) begin
            pos_col = 0;
            pos_row = last_row ? 0 : pos_row + 1;
        end else begin
            pos_col = pos_col + 1;
        end
    endtask

    task automatic clearModel();
        exp_q.delete();
        src_q.delete();
        pos_col = 0;
        pos_row = 0;
    endtask

    task automatic updateDrive();
        in_valid = push_en && (src_q.size() != 0);
        in_pixel = (src_q.size() != 0) ? src_q[0] : 24'h0;
    endtask

    // One clock: score the beat and the pixel that transfer on this edge.
    task automatic applyStimulus();
        logic        in_x;
        logic        out_x;
        logic        fd_exp;
        logic [12:0] beat;
        logic [12:0] e;
        in_x   = in_valid && in_ready;
        out_x  = out_valid && out_ready;
        fd_exp = 1'b0;
        if (flush) begin
            clearModel();
        end else begin
            if (out_x) begin
                beat = {out_data, out_chan, out_sof, out_eol, out_eof};
                if (check_b24 && beat_cnt == 24) checkOutput("sof_beat24", {31'd0, out_sof}, 32'd1);
                if (exp_q.size() == 0) begin
                    checkOutput("beat_extra", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("beat", {19'd0, beat}, {19'd0, e});
                    fd_exp = e[0];
                end
                beat_cnt++;
            end
            if (in_x) modelPush(src_q.pop_front());
        end
        @(negedge clk);
        checkOutput("frame_done", {31'd0, frame_done}, {31'd0, fd_exp});
        updateDrive();
    endtask

    task automatic drain(input int max_cycles);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || src_q.size() != 0) && n < max_cycles) begin
            applyStimulus();
            n++;
        end
        checkOutput("drain_left", exp_q.size() + src_q.size(), 32'd0);
    endtask

    initial begin
        logic found;
        n_compared   = 0;
        n_mismatched = 0;
        beat_cnt     = 0;
        check_b24    = 1'b0;
        push_en      = 1'b0;
        rst_n        = 1'b0;
        flush        = 1'b0;
        in_valid     = 1'b0;
        in_pixel     = 24'h0;
        out_ready    = 1'b0;
        clearModel();

        // Reset values, then ready only after the first edge past release.
        @(negedge clk);
        checkOutput("rst_outputs", {out_valid, out_data, out_chan, out_sof, out_eol, out_eof, frame_done, in_ready}, 32'd0);
        #2 rst_n = 1'b1;
        #1 checkOutput("ready_before_edge", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        checkOutput("ready_after_edge", {31'd0, in_ready}, 32'd1);

        // One full frame at full rate, with first-pixel latency checked.
        $display("[TB] frame at full rate");
        for (int n = 0; n < 8; n++) src_q.push_back({8'(n), 8'(n + 16), 8'(n + 32)});
        push_en   = 1'b1;
        out_ready = 1'b1;
        beat_cnt  = 0;
        updateDrive();
        applyStimulus();
        checkOutput("latency_c1_valid", {31'd0, out_valid}, 32'd0);
        applyStimulus();
        checkOutput("latency_c2_beat", {22'd0, out_valid, out_data, out_sof}, {22'd0, 1'b1, 8'h00, 1'b1});
        drain(200);
        checkOutput("frame1_beats", beat_cnt, 32'd24);

        // Backpressure: buffer fills, first beat holds, then drains intact.
        $display("[TB] backpressure");
        out_ready = 1'b0;
        for (int n = 0; n < 8; n++) src_q.push_back({8'(n + 8'h40), 8'(n + 8'h50), 8'(n + 8'h60)});
        updateDrive();
        for (int i = 0; i < 12; i++) applyStimulus();
        checkOutput("accepted_when_stalled", 32'(8 - src_q.size()), 32'd4);
        checkOutput("in_ready_full", {31'd0, in_ready}, 32'd0);
        for (int i = 0; i < 10; i++) begin
            checkOutput("stall_hold", {18'd0, out_valid, out_data, out_chan, out_sof, out_eol, out_eof}, {18'd0, 1'b1, exp_q[0]});
            applyStimulus();
        end
        out_ready = 1'b1;
        drain(200);

        // Two back-to-back frames with a 50% downstream duty cycle.
        $display("[TB] toggling ready over two frames");
        for (int n = 0; n < 16; n++) src_q.push_back({8'(n + 8'h80), 8'(n + 8'h90), 8'(n + 8'hA0)});
        beat_cnt  = 0;
        check_b24 = 1'b1;
        updateDrive();
        for (int i = 0; i < 400 && (exp_q.size() != 0 || src_q.size() != 0); i++) begin
            out_ready = ~out_ready;
            applyStimulus();
        end
        checkOutput("two_frame_left", exp_q.size() + src_q.size(), 32'd0);
        checkOutput("two_frame_beats", beat_cnt, 32'd48);
        check_b24 = 1'b0;

        // Flush while pixel 5 shows its green beat.
        $display("[TB] flush mid-frame");
        out_ready = 1'b1;
        for (int n = 0; n < 8; n++) src_q.push_back({8'(n), 8'(n + 16), 8'(n + 32)});
        updateDrive();
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            if (out_valid && out_chan == 2'd1 && out_data == 8'd21) found = 1'b1;
            else applyStimulus();
        end
        checkOutput("flush_point_found", {31'd0, found}, 32'd1);
        flush     = 1'b1;
        out_ready = 1'b0;
        push_en   = 1'b0;
        updateDrive();
        applyStimulus();
        flush = 1'b0;
        checkOutput("flush_idle", {31'd0, out_valid}, 32'd0);
        checkOutput("flush_ready", {31'd0, in_ready}, 32'd1);
        applyStimulus();
        applyStimulus();
        checkOutput("flush_empty", {31'd0, out_valid}, 32'd0);
        out_ready = 1'b1;
        push_en   = 1'b1;
        src_q.push_back(24'h123456);
        updateDrive();
        drain(50);

        // Asynchronous reset in the middle of a held beat.
        $display("[TB] async reset mid-beat");
        out_ready = 1'b0;
        for (int n = 0; n < 3; n++) src_q.push_back({8'(n + 1), 8'(n + 2), 8'(n + 3)});
        updateDrive();
        for (int i = 0; i < 6; i++) applyStimulus();
        push_en = 1'b0;
        updateDrive();
        #2 rst_n = 1'b0;
        #1 checkOutput("async_rst", {out_valid, out_data, out_chan, out_sof, out_eol, out_eof, frame_done, in_ready}, 32'd0);
        clearModel();
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        checkOutput("rst_ready_again", {31'd0, in_ready}, 32'd1);
        out_ready = 1'b1;
        push_en   = 1'b1;
        beat_cnt  = 0;
        src_q.push_back(24'hAA5511);
        updateDrive();
        drain(50);
        checkOutput("post_rst_beats", beat_cnt, 32'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
